// File: rtl/core_btb_pred.sv
// Two-way set-associative branch target buffer with the IF->ID prediction register.
// IF-stage lookup forms next_pc; ID-stage resolution drives predictor updates, BTB writes and redirects.
module core_btb_pred #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] if_pc,
  input  logic            if_valid,
  input  logic            pht_pred,
  input  logic [1:0]      pht_cnt,
  input  logic [3:0]      bhr_rd,
  input  logic            stall,
  input  logic            flush,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  output logic [PC_W-1:0] next_pc,
  output logic [PC_W-1:0] id_pc,
  output logic [3:0]      BHR_in,
  output logic [1:0]      delayed_PHT,
  output logic            update_BP,
  output logic            pred_right,
  output logic            taken,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc
);

  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int SETS  = 1 << IDX_W;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [PC_W-3:0]  tgt_t;

  // BTB storage: bit/element index [w] selects the way
  logic [1:0]      valid_q [SETS];
  logic [1:0]      valid_d [SETS];
  tag_t            tag_q   [SETS][2];
  tag_t            tag_d   [SETS][2];
  tgt_t            target_q[SETS][2];
  tgt_t            target_d[SETS][2];
  logic [SETS-1:0] lru_q, lru_d;

  // IF/ID pipeline register
  logic            id_valid_q, id_valid_d;
  logic [PC_W-1:0] id_pc_q, id_pc_d;
  logic [3:0]      bhr_q, bhr_d;
  logic [1:0]      pht_q, pht_d;
  logic [PC_W-1:0] id_pred_tgt_q, id_pred_tgt_d;

  logic [IDX_W-1:0] if_set, id_set;
  tag_t             if_tag, id_tag;
  logic             if_hit0, if_hit1, if_hit, pred_taken_if;
  logic             id_hit0, id_hit1, upd, wr_way;
  tgt_t             hit_tgt;
  logic [PC_W-1:0]  correct_pc;

  assign if_set = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign id_set = id_pc_q[IDX_W+1:2];
  assign id_tag = id_pc_q[PC_W-1:IDX_W+2];

  // Lookup sees the pre-write array, so a same-cycle write shows up one cycle later.
  always_comb begin
    if_hit0       = valid_q[if_set][0] && (tag_q[if_set][0] == if_tag);
    if_hit1       = valid_q[if_set][1] && (tag_q[if_set][1] == if_tag);
    if_hit        = if_hit0 | if_hit1;
    hit_tgt       = if_hit0 ? target_q[if_set][0] : target_q[if_set][1];
    pred_taken_if = if_valid & if_hit & pht_pred;
    next_pc       = pred_taken_if ? {hit_tgt, 2'b00} : if_pc + PC_W'(4);
  end

  always_comb begin
    upd         = res_valid & id_valid_q;
    correct_pc  = res_taken ? res_target : id_pc_q + PC_W'(4);
    update_BP   = upd;
    pred_right  = upd & (pht_q[1] == res_taken);
    taken       = upd & res_taken;
    redirect    = upd & (id_pred_tgt_q != correct_pc);
    redirect_pc = redirect ? correct_pc : '0;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    lru_d    = lru_q;
    id_hit0  = valid_q[id_set][0] && (tag_q[id_set][0] == id_tag);
    id_hit1  = valid_q[id_set][1] && (tag_q[id_set][1] == id_tag);
    wr_way   = 1'b0;
    if (upd && !stall) begin
      if (res_taken) begin
        if (id_hit0)                  wr_way = 1'b0;
        else if (id_hit1)             wr_way = 1'b1;
        else if (!valid_q[id_set][0]) wr_way = 1'b0;
        else if (!valid_q[id_set][1]) wr_way = 1'b1;
        else                          wr_way = lru_q[id_set];
        valid_d[id_set][wr_way]  = 1'b1;
        tag_d[id_set][wr_way]    = id_tag;
        target_d[id_set][wr_way] = correct_pc[PC_W-1:2];
        lru_d[id_set]            = ~wr_way;
      end else if (id_hit0 || id_hit1) begin
        lru_d[id_set] = id_hit0;
      end
    end
  end

  // A squash (external or mispredict) outranks stall and zeroes the whole slot.
  always_comb begin
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    bhr_d         = bhr_q;
    pht_d         = pht_q;
    id_pred_tgt_d = id_pred_tgt_q;
    if (flush || redirect) begin
      id_valid_d    = 1'b0;
      id_pc_d       = '0;
      bhr_d         = '0;
      pht_d         = '0;
      id_pred_tgt_d = '0;
    end else if (!stall) begin
      id_valid_d    = if_valid;
      id_pc_d       = if_pc;
      bhr_d         = bhr_rd;
      pht_d         = pht_cnt;
      id_pred_tgt_d = next_pc;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '{default: '0};
      lru_q         <= '0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      bhr_q         <= '0;
      pht_q         <= '0;
      id_pred_tgt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      lru_q         <= lru_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      bhr_q         <= bhr_d;
      pht_q         <= pht_d;
      id_pred_tgt_q <= id_pred_tgt_d;
    end
  end

  // NOTE: tag/target arrays carry no reset; the reset valid bits make their contents irrelevant.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign id_pc       = id_pc_q;
  assign BHR_in      = bhr_q;
  assign delayed_PHT = pht_q;

endmodule

// File: tb/tb_core_btb_pred.sv
// Directed bench for core_btb_pred: resolution responses go through a scoreboard queue
// checked by a negedge monitor; lookups and register holds are checked inline.
module tb_core_btb_pred;

  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [PC_W-1:0] if_pc;
  logic            if_valid, pht_pred, stall, flush, res_valid, res_taken;
  logic [1:0]      pht_cnt;
  logic [3:0]      bhr_rd;
  logic [PC_W-1:0] res_target;
  logic [PC_W-1:0] next_pc, id_pc, redirect_pc;
  logic [3:0]      BHR_in;
  logic [1:0]      delayed_PHT;
  logic            update_BP, pred_right, taken, redirect;

  core_btb_pred #(.PC_W(PC_W), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_valid(if_valid), .pht_pred(pht_pred),
    .pht_cnt(pht_cnt), .bhr_rd(bhr_rd), .stall(stall), .flush(flush),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .next_pc(next_pc), .id_pc(id_pc), .BHR_in(BHR_in), .delayed_PHT(delayed_PHT),
    .update_BP(update_BP), .pred_right(pred_right), .taken(taken),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        pr;
    logic        tk;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_res(input string name, input logic pr, input logic tk,
                            input logic rd, input logic [31:0] rpc);
    sb_q.push_back('{name, pr, tk, rd, rpc});
  endtask

  task automatic set_if(input logic [31:0] pc, input logic v, input logic pred,
                        input logic [1:0] cnt, input logic [3:0] bhr);
    if_pc = pc; if_valid = v; pht_pred = pred; pht_cnt = cnt; bhr_rd = bhr;
  endtask

  task automatic set_res(input logic v, input logic tk, input logic [31:0] tgt);
    res_valid = v; res_taken = tk; res_target = tgt;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic [31:0] exp);
    set_if(pc, 1'b1, 1'b1, 2'b11, 4'h0);
    #1;
    check(name, next_pc, exp);
  endtask

  // Monitor: every update strobe consumes one expectation; idle cycles must be quiet.
  always @(negedge clk) begin
    if (!rst) begin
      if (update_BP) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: update_BP=1 redirect=%0b redirect_pc=0x%0h, none expected",
                   redirect, redirect_pc);
        end else begin
          mon_e = sb_q.pop_front();
          check({mon_e.name, "_pred_right"}, 32'(pred_right), 32'(mon_e.pr));
          check({mon_e.name, "_taken"}, 32'(taken), 32'(mon_e.tk));
          check({mon_e.name, "_redirect"}, 32'(redirect), 32'(mon_e.rd));
          check({mon_e.name, "_redirect_pc"}, redirect_pc, mon_e.rpc);
        end
      end else begin
        check("idle_quiet", {29'd0, redirect, taken, pred_right}, 32'd0);
        check("idle_redirect_pc", redirect_pc, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_if(32'h0, 1'b0, 1'b0, 2'b00, 4'h0);
    set_res(1'b0, 1'b0, 32'h0);

    @(negedge clk);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_bhr", 32'(BHR_in), 32'h0);
    check("rst_pht", 32'(delayed_PHT), 32'h0);
    check("rst_update", 32'(update_BP), 32'h0);
    check("rst_next_pc", next_pc, 32'h4);
    #2 rst = 1'b0;

    // First fetch misses
    set_if(32'h100, 1'b1, 1'b1, 2'b01, 4'h3);
    #1 check("first_miss", next_pc, 32'h104);
    next_cycle();

    // Hold the branch in ID for one cycle with no resolution
    stall = 1'b1;
    set_if(32'h104, 1'b1, 1'b0, 2'b00, 4'h0);
    @(negedge clk);
    check("hold_update", 32'(update_BP), 32'h0);
    check("hold_redirect", 32'(redirect), 32'h0);
    check("cap_id_pc", id_pc, 32'h100);
    check("cap_bhr", 32'(BHR_in), 32'h3);
    check("cap_pht", 32'(delayed_PHT), 32'h1);
    next_cycle();

    // Taken, predicted fall-through: install 0x100->0x200
    stall = 1'b0;
    set_res(1'b1, 1'b1, 32'h200);
    expect_res("br_miss", 1'b0, 1'b1, 1'b1, 32'h200);
    next_cycle();

    // Slot squashed by redirect; lookup now hits
    set_if(32'h100, 1'b1, 1'b1, 2'b11, 4'h5);
    @(negedge clk);
    check("squashed_update", 32'(update_BP), 32'h0);
    check("hit_100", next_pc, 32'h200);
    next_cycle();

    // Predicted taken, actually not taken
    set_res(1'b1, 1'b0, 32'h0);
    expect_res("br_nt", 1'b0, 1'b0, 1'b1, 32'h104);
    set_if(32'h0, 1'b0, 1'b0, 2'b00, 4'h0);
    @(negedge clk);
    check("nt_id_pc", id_pc, 32'h100);
    check("nt_pht", 32'(delayed_PHT), 32'h3);
    check("nt_bhr", 32'(BHR_in), 32'h5);
    next_cycle();

    // Correctly predicted taken
    set_res(1'b0, 1'b0, 32'h0);
    set_if(32'h100, 1'b1, 1'b1, 2'b11, 4'h0);
    #1 check("hit_100_again", next_pc, 32'h200);
    next_cycle();
    set_res(1'b1, 1'b1, 32'h200);
    expect_res("br_ok", 1'b1, 1'b1, 1'b0, 32'h0);
    set_if(32'h500, 1'b1, 1'b1, 2'b00, 4'h0);
    #1 check("miss_500", next_pc, 32'h504);
    next_cycle();

    // Install 0x500 -> 0x600 into way1
    set_res(1'b1, 1'b1, 32'h600);
    expect_res("inst_500", 1'b0, 1'b1, 1'b1, 32'h600);
    set_if(32'h0, 1'b0, 1'b0, 2'b00, 4'h0);
    next_cycle();

    // Install 0x900 -> 0xA00: set full, evicts LRU way holding 0x100
    set_res(1'b0, 1'b0, 32'h0);
    set_if(32'h900, 1'b1, 1'b1, 2'b10, 4'h0);
    #1 check("miss_900", next_pc, 32'h904);
    next_cycle();
    set_res(1'b1, 1'b1, 32'hA00);
    expect_res("inst_900", 1'b1, 1'b1, 1'b1, 32'hA00);
    set_if(32'h0, 1'b0, 1'b0, 2'b00, 4'h0);
    next_cycle();

    set_res(1'b0, 1'b0, 32'h0);
    lookup("evicted_100", 32'h100, 32'h104);
    lookup("hit_900", 32'h900, 32'hA00);
    lookup("hit_500", 32'h500, 32'h600);
    next_cycle();

    // Taken hit on 0x500 makes 0x900's way the victim
    set_res(1'b1, 1'b1, 32'h600);
    expect_res("hit_500_res", 1'b1, 1'b1, 1'b0, 32'h0);
    set_if(32'hD00, 1'b1, 1'b1, 2'b00, 4'h0);
    #1 check("miss_D00", next_pc, 32'hD04);
    next_cycle();
    set_res(1'b1, 1'b1, 32'hE00);
    expect_res("inst_D00", 1'b0, 1'b1, 1'b1, 32'hE00);
    set_if(32'h0, 1'b0, 1'b0, 2'b00, 4'h0);
    next_cycle();

    set_res(1'b0, 1'b0, 32'h0);
    lookup("evicted_900", 32'h900, 32'h904);
    lookup("kept_500", 32'h500, 32'h600);
    lookup("hit_D00", 32'hD00, 32'hE00);

    // Stall holds the IF/ID register
    set_if(32'h40, 1'b1, 1'b0, 2'b01, 4'h9);
    #1 check("miss_40", next_pc, 32'h44);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      set_if(32'h80 + 32'(i) * 32'h40, 1'b1, 1'b0, 2'(i + 2), 4'(i));
      @(negedge clk);
      check("stall_id_pc", id_pc, 32'h40);
      check("stall_bhr", 32'(BHR_in), 32'h9);
      check("stall_pht", 32'(delayed_PHT), 32'h1);
      next_cycle();
    end

    // Flush outranks stall
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    set_res(1'b1, 1'b1, 32'h80);
    @(negedge clk);
    check("flush_update", 32'(update_BP), 32'h0);
    check("flush_id_pc", id_pc, 32'h0);
    next_cycle();
    stall = 1'b0;
    set_res(1'b0, 1'b0, 32'h0);

    // Async reset during a pending BTB write
    set_if(32'h144, 1'b1, 1'b1, 2'b11, 4'h7);
    #1 check("miss_144", next_pc, 32'h148);
    next_cycle();
    set_res(1'b1, 1'b1, 32'h300);
    set_if(32'h0, 1'b0, 1'b0, 2'b00, 4'h0);
    #1 check("pending_redirect", 32'(redirect), 32'h1);
    #1 rst = 1'b1;
    #1;
    check("arst_update", 32'(update_BP), 32'h0);
    check("arst_redirect", {31'd0, redirect}, 32'h0);
    check("arst_redirect_pc", redirect_pc, 32'h0);
    check("arst_id_pc", id_pc, 32'h0);
    check("arst_bhr_pht", {26'd0, BHR_in, delayed_PHT}, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    set_res(1'b0, 1'b0, 32'h0);
    lookup("post_rst_144", 32'h144, 32'h148);
    lookup("post_rst_500", 32'h500, 32'h504);
    next_cycle();
    next_cycle();

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_btb_pred.md
Name: core_btb_pred

Overview:
- Branch Target Buffer plus IF→ID prediction pipeline register for the core front end.
- In IF it looks up if_pc, combines a BTB hit with the pattern-history predictor's direction bit, and produces next_pc.
- It carries the IF-stage predictor state (BHR read, 2-bit counter, prediction) into ID.
- In ID it resolves the branch and drives the predictor update signals (update_BP, pred_right, taken, BHR_in, delayed_PHT, id_pc) and a redirect on mispredict.

Parameters:
PC_W, 32, program counter width (byte address, bits [1:0] always 0)
IDX_W, 4, set-index width; 2^IDX_W sets, 2 ways per set
TAG_W, PC_W-IDX_W-2, stored tag width (derived; not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
if_pc  in  PC_W  fetch PC
if_valid  in  1  fetch slot holds a real instruction
pht_pred  in  1  direction prediction for if_pc (1 = taken)
pht_cnt  in  2  2-bit counter read for if_pc
bhr_rd  in  4  branch history read for if_pc
stall  in  1  hold the IF/ID register
flush  in  1  external squash of the IF/ID register
res_valid  in  1  ID-stage instruction is a branch with a known outcome this cycle
res_taken  in  1  actual direction
res_target  in  PC_W  actual taken target
next_pc  out  PC_W  predicted next fetch PC (combinational)
id_pc  out  PC_W  registered PC of the ID-stage slot
BHR_in  out  4  registered bhr_rd
delayed_PHT  out  2  registered pht_cnt
update_BP  out  1  predictor update strobe
pred_right  out  1  direction prediction was correct
taken  out  1  = res_taken when update_BP, else 0
redirect  out  1  mispredict; front end must load redirect_pc
redirect_pc  out  PC_W  corrected fetch PC

Behaviour:
- Address split: set = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Each way holds: valid, tag, target[PC_W-1:2]. Each set holds 1 LRU bit naming the victim way.
- Lookup is combinational: hit when a valid way in set(if_pc) matches tag(if_pc).
- pred_taken_if = if_valid & hit & pht_pred. next_pc = pred_taken_if ? hit target : if_pc+4. Addition wraps modulo 2^PC_W.
- IF/ID register fields: id_valid, id_pc, BHR_in, delayed_PHT, id_hit, id_pred_taken, id_pred_tgt.
  - rst, flush or redirect: id_valid←0; other fields are don't-care but are reset to 0.
  - flush/redirect has priority over stall.
  - stall (no flush/redirect): all fields hold.
  - Otherwise: capture if_valid, if_pc, bhr_rd, pht_cnt, hit, pred_taken_if and next_pc.
- Resolution, combinational from ID-stage state; upd = res_valid & id_valid:
  - update_BP = upd.
  - pred_right = upd & (delayed_PHT[1] == res_taken).
  - taken = upd & res_taken.
  - correct_pc = res_taken ? res_target : id_pc+4.
  - redirect = upd & (id_pred_tgt != correct_pc); redirect_pc = correct_pc. redirect_pc is 0 when redirect=0.
  - Non-branch ID slots (res_valid=0) never redirect.
- BTB write, at the clock edge when upd & res_taken, into set(id_pc):
  - Matching way: overwrite its target.
  - No match: write the first invalid way (way0 before way1). If both ways are valid, write the LRU way.
  - Set valid=1. LRU←other way than the one written.
  - upd & !res_taken & tag match: LRU←other way, entry kept.
  - No write when stall=1 (resolution is repeated next cycle).
- Same-cycle lookup and write to the same set: lookup returns pre-write contents; the write is visible the next cycle.
- Async reset: all valid bits 0, all LRU bits 0, id_valid 0, registered outputs 0. Deassertion takes effect from the first following edge.
- Reset mid-operation aborts any pending write. The first fetch after reset predicts if_pc+4.

Test Plan:
- Reset, then if_pc=0x100, pht_pred=1 → next_pc=0x104 (miss); after one clock, update_BP=0 and redirect=0.
- Branch at 0x100 in ID, res_valid=1, res_taken=1, res_target=0x200, id_pred_tgt=0x104 → redirect=1, redirect_pc=0x200, update_BP=1, taken=1. Next cycle id_valid=0. Lookup 0x100 with pht_pred=1 → next_pc=0x200.
- Same branch hits with delayed_PHT=2'b11 and actual not-taken → pred_right=0, taken=0, redirect=1, redirect_pc=0x104.
- IDX_W=4: install 0x100→0x200 and 0x500→0x600 (same set 0), then 0x900→0xA00 → way holding 0x100 is evicted, 0x500 still hits. Then hit 0x500 resolved taken → LRU points to 0x900's way.
- stall=1 for 3 cycles with a new if_pc each cycle → id_pc, BHR_in, delayed_PHT held. flush=1 together with stall=1 → id_valid=0 next cycle.
- Assert rst asynchronously mid-cycle during a pending BTB write → outputs 0 immediately. After release, lookup of the written PC misses (next_pc=PC+4).
